// File: rtl/dma_pkg.sv
// Shared types and constants for the data-memory word-copy DMA.
package dma_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_dma_copier.sv
// Word-copy DMA initiator: alternates read/write requests on the data-memory
// port to copy len words from src to dst, summing the words copied.
module dmem_dma_copier
    import dma_pkg::*;
#(
    parameter int unsigned p_len_nbits = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      src_addr,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [p_len_nbits-1:0] len,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      sum,
    output logic                   dmemreq_val,
    output logic                   dmemreq_type,
    output logic [ADDR_W-1:0]      dmemreq_addr,
    output logic [DATA_W-1:0]      dmemreq_wdata,
    input  logic [DATA_W-1:0]      dmemresp_rdata
);

    localparam logic [p_len_nbits-1:0] LEN_ONE  = p_len_nbits'(1);
    localparam logic [ADDR_W-1:0]      PTR_STEP = ADDR_W'(WORD_BYTES);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      src_q, src_d;
    logic [ADDR_W-1:0]      dst_q, dst_d;
    logic [p_len_nbits-1:0] count_q, count_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      sum_q, sum_d;

    logic                   busy_d, done_d, val_d, type_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [DATA_W-1:0]      wdata_d;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        data_d  = data_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = word_align(src_addr);
                    dst_d   = word_align(dst_addr);
                    count_d = len;
                    sum_d   = '0;
                    state_d = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                data_d  = dmemresp_rdata;
                sum_d   = sum_q + dmemresp_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                src_d   = src_q + PTR_STEP;
                dst_d   = dst_q + PTR_STEP;
                count_d = count_q - LEN_ONE;
                state_d = (count_q == LEN_ONE) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port values for the upcoming cycle, decoded from the next state so the
    // outputs can be driven straight from flops.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        val_d   = 1'b0;
        type_d  = MEMREQ_READ;
        addr_d  = '0;
        wdata_d = '0;
        unique case (state_d)
            READ: begin
                busy_d = 1'b1;
                val_d  = 1'b1;
                type_d = MEMREQ_READ;
                addr_d = src_d;
            end
            WRITE: begin
                busy_d  = 1'b1;
                val_d   = 1'b1;
                type_d  = MEMREQ_WRITE;
                addr_d  = dst_d;
                wdata_d = data_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            count_q       <= '0;
            data_q        <= '0;
            sum_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            dmemreq_val   <= 1'b0;
            dmemreq_type  <= MEMREQ_READ;
            dmemreq_addr  <= '0;
            dmemreq_wdata <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            count_q       <= count_d;
            data_q        <= data_d;
            sum_q         <= sum_d;
            busy          <= busy_d;
            done          <= done_d;
            dmemreq_val   <= val_d;
            dmemreq_type  <= type_d;
            dmemreq_addr  <= addr_d;
            dmemreq_wdata <= wdata_d;
        end
    end

    assign sum = sum_q;

endmodule
